// File: rtl/day05_input_writer.sv
// day05_input_writer: formats range/separator/id records as an ASCII byte stream for a memory writer
module day05_input_writer #(
  parameter int N_ADDR_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rec_valid,
  output logic                   rec_ready,
  input  logic [1:0]             rec_type,
  input  logic [63:0]            rec_a,
  input  logic [63:0]            rec_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [N_ADDR_BITS:0]   out_addr,
  output logic [N_ADDR_BITS+1:0] byte_count,
  output logic                   done,
  output logic                   err
);
  typedef enum logic [1:0] {IDLE, CONV, EMIT, DONE} state_t;
  localparam logic [N_ADDR_BITS+1:0] cap = {1'b1, {(N_ADDR_BITS+1){1'b0}}};
  state_t state, state_nxt;
  logic [63:0] q, b_r, q_div;
  logic [3:0] rem;
  logic [3:0] dbuf [20];
  logic [4:0] ndig;
  logic is_range, phase, last, sep_seen;
  logic acc, fire, bad, load, full, ovf;
  logic [N_ADDR_BITS+1:0] cnt_nxt;
  assign q_div = q / 64'd10;
  assign rem = 4'(q % 64'd10);
  always_comb begin
    acc = rec_valid && rec_ready;
    fire = out_valid && out_ready;
    bad = acc && (rec_type == 2'd2 ? !sep_seen : rec_type != 2'd3 && sep_seen);
    cnt_nxt = byte_count + {{(N_ADDR_BITS+1){1'b0}}, fire};
    full = cnt_nxt == cap;
    load = state == IDLE ? acc && rec_type == 2'd1 && !bad :
           state == CONV ? q_div == 64'd0 :
           state == EMIT && fire && !last;
    ovf = load && full;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc && !bad) state_nxt = rec_type == 2'd3 ? DONE : rec_type == 2'd1 ? EMIT : CONV;
      CONV: if (q_div == 64'd0) state_nxt = EMIT;
      EMIT: if (fire && last) state_nxt = is_range && !phase ? CONV : IDLE;
      default: state_nxt = state;
    endcase
    if (ovf) state_nxt = DONE;
  end
  always_comb begin
    rec_ready = state == IDLE && !rst;
    done = state == DONE;
    out_addr = byte_count[N_ADDR_BITS:0];
  end
  // digits are stored LSB-first; the MSB goes straight to out_data and the rest are replayed downward
  always_ff @(posedge clk)
    if (state == CONV && q_div != 64'd0) dbuf[ndig] <= rem;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= 8'h00;
      byte_count <= '0;
      err <= 1'b0;
      sep_seen <= 1'b0;
      q <= 64'd0;
      b_r <= 64'd0;
      ndig <= 5'd0;
      is_range <= 1'b0;
      phase <= 1'b0;
      last <= 1'b0;
    end else begin
      byte_count <= cnt_nxt;
      err <= err || bad || ovf;
      out_valid <= load ? !full : out_valid && !fire;
      case (state)
        IDLE: if (acc && !bad) begin
          sep_seen <= sep_seen || rec_type == 2'd1;
          q <= rec_a;
          b_r <= rec_b;
          is_range <= rec_type == 2'd0;
          phase <= 1'b0;
          ndig <= 5'd0;
          out_data <= 8'h0A;
          last <= 1'b1;
        end
        CONV: if (q_div != 64'd0) begin
          ndig <= ndig + 5'd1;
          q <= q_div;
        end else begin
          out_data <= {4'h3, rem};
          last <= 1'b0;
        end
        EMIT: if (fire) begin
          if (last) begin
            q <= b_r;
            phase <= 1'b1;
          end else if (ndig != 5'd0) begin
            out_data <= {4'h3, dbuf[ndig-5'd1]};
            ndig <= ndig - 5'd1;
          end else begin
            out_data <= is_range && !phase ? 8'h2D : 8'h0A;
            last <= 1'b1;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_day05_input_writer.sv
// tb_day05_input_writer: randomized and directed checks of the record formatter against a string-based model
module tb_day05_input_writer;
  logic clk = 1'b0, rst = 1'b1, rec_valid = 1'b0, out_ready = 1'b1, sel = 1'b0;
  logic [1:0] rec_type = 2'd0;
  logic [63:0] rec_a = 64'd0, rec_b = 64'd0;
  logic rr1, ov1, dn1, er1, rr2, ov2, dn2, er2;
  logic [7:0] od1, od2;
  logic [16:0] oa1;
  logic [2:0] oa2;
  logic [17:0] bc1;
  logic [3:0] bc2;
  logic rr, ov, dn, er;
  logic [7:0] od;
  logic [16:0] oa;
  logic [17:0] bc;
  typedef struct { logic [1:0] t; logic [63:0] a; logic [63:0] b; } rec_t;
  rec_t recs[$];
  logic [7:0] got_d[$];
  int got_a[$];
  logic [7:0] exp_q[$];
  bit exp_err, exp_done;
  int total = 0, passed = 0, rdy_mode = 0, pi = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_d;
  int prev_a;

  day05_input_writer dut (.clk(clk), .rst(rst), .rec_valid(rec_valid && !sel), .rec_ready(rr1),
    .rec_type(rec_type), .rec_a(rec_a), .rec_b(rec_b), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_addr(oa1), .byte_count(bc1), .done(dn1), .err(er1));
  day05_input_writer #(.N_ADDR_BITS(2)) dut_small (.clk(clk), .rst(rst), .rec_valid(rec_valid && sel),
    .rec_ready(rr2), .rec_type(rec_type), .rec_a(rec_a), .rec_b(rec_b), .out_valid(ov2),
    .out_ready(out_ready), .out_data(od2), .out_addr(oa2), .byte_count(bc2), .done(dn2), .err(er2));

  assign rr = sel ? rr2 : rr1;
  assign ov = sel ? ov2 : ov1;
  assign dn = sel ? dn2 : dn1;
  assign er = sel ? er2 : er1;
  assign od = sel ? od2 : od1;
  assign oa = sel ? 17'(oa2) : oa1;
  assign bc = sel ? 18'(bc2) : bc1;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    pi++;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : (pi % 4 == 0 || pi % 4 == 3);
  end

  always @(posedge clk) begin
    if (rst) begin
      got_d.delete();
      got_a.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!ov || od !== prev_d || int'(oa) !== prev_a)
          $display("FAIL stall_hold: valid=%0b data=%h addr=%0d, required valid=1 data=%h addr=%0d", ov, od, oa, prev_d, prev_a);
        else passed++;
      end
      if (ov && out_ready) begin
        got_d.push_back(od);
        got_a.push_back(int'(oa));
      end
      prev_stall = ov && !out_ready;
      prev_d = od;
      prev_a = int'(oa);
    end
  end

  function automatic rec_t mk(input logic [1:0] t, input logic [63:0] a, input logic [63:0] b);
    rec_t r;
    r.t = t;
    r.a = a;
    r.b = b;
    return r;
  endfunction

  function automatic logic [63:0] rv();
    case ($urandom_range(0, 3))
      0: return 64'($urandom_range(0, 99));
      1: return 64'($urandom_range(0, 99999));
      2: return {$urandom, $urandom};
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  task automatic model(input int cap);
    bit sep = 0;
    string s;
    exp_q.delete();
    exp_err = 0;
    exp_done = 0;
    foreach (recs[i]) begin
      if (exp_done) break;
      s = "";
      case (recs[i].t)
        2'd3: exp_done = 1;
        2'd1: if (sep) exp_err = 1; else begin sep = 1; s = "\n"; end
        2'd0: if (sep) exp_err = 1; else s = $sformatf("%0d-%0d\n", recs[i].a, recs[i].b);
        default: if (!sep) exp_err = 1; else s = $sformatf("%0d\n", recs[i].a);
      endcase
      for (int k = 0; k < s.len(); k++) begin
        if (exp_q.size() == cap) begin exp_err = 1; exp_done = 1; break; end
        exp_q.push_back(s[k]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic send(input rec_t r);
    int n = 0;
    @(negedge clk);
    rec_valid = 1'b1;
    rec_type = r.t;
    rec_a = r.a;
    rec_b = r.b;
    while (!rr && !dn && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin total++; $display("FAIL send_timeout: rec_ready=%0b after %0d cycles, required 1", rr, n); end
    if (rr) @(posedge clk);
    #1 rec_valid = 1'b0;
  endtask

  task automatic run_recs(input bit rst_first, input int start);
    int n = 0;
    if (rst_first) do_reset();
    for (int i = start; i < recs.size(); i++) begin
      if (dn) break;
      send(recs[i]);
    end
    while (!dn && n < 3000) begin @(negedge clk); n++; end
    model(sel ? 8 : 131072);
    total++;
    if (got_d.size() !== exp_q.size()) $display("FAIL stream_len: got %0d bytes, required %0d", got_d.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_d[i] !== exp_q[i] || got_a[i] !== i)
        $display("FAIL byte[%0d]: got %h@%0d, required %h@%0d", i, got_d[i], got_a[i], exp_q[i], i);
      else passed++;
    end
    total++;
    if (bc !== 18'(exp_q.size()) || er !== exp_err || dn !== exp_done || ov !== 1'b0)
      $display("FAIL final: byte_count=%0d err=%0b done=%0b valid=%0b, required %0d %0b %0b 0", bc, er, dn, ov, exp_q.size(), exp_err, exp_done);
    else passed++;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1;
    total++;
    if (rr !== 1'b0) $display("FAIL reset_ready_low: got %0b, required 0", rr); else passed++;
    @(posedge clk) #1;
    total++;
    if (ov !== 1'b0 || od !== 8'h00 || oa !== 17'd0 || bc !== 18'd0 || dn !== 1'b0 || er !== 1'b0)
      $display("FAIL reset_values: valid=%0b data=%h addr=%0d count=%0d done=%0b err=%0b, required all 0", ov, od, oa, bc, dn, er);
    else passed++;
    @(negedge clk) rst = 1'b0;
    #1;
    total++;
    if (rr !== 1'b1) $display("FAIL reset_ready_high: got %0b, required 1", rr); else passed++;
  endtask

  task automatic test_basic();
    rdy_mode = 0;
    recs = '{mk(2'd0, 64'd3, 64'd5), mk(2'd1, 0, 0), mk(2'd2, 64'd17, 0), mk(2'd3, 0, 0)};
    run_recs(1, 0);
  endtask

  task automatic test_id_extremes();
    int lat = 1;
    rdy_mode = 0;
    do_reset();
    recs = '{mk(2'd1, 0, 0), mk(2'd2, 64'd0, 0), mk(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0), mk(2'd3, 0, 0)};
    send(recs[0]);
    send(recs[1]);
    send(recs[2]);
    while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat !== 21) $display("FAIL id_max_latency: got %0d cycles, required 21", lat); else passed++;
    run_recs(0, 3);
  endtask

  task automatic test_stall();
    rdy_mode = 2;
    recs = '{mk(2'd0, 64'd10, 64'd20), mk(2'd3, 0, 0)};
    run_recs(1, 0);
    rdy_mode = 0;
  endtask

  task automatic test_order_err();
    rdy_mode = 0;
    do_reset();
    recs = '{mk(2'd2, 64'd7, 0), mk(2'd0, 64'd4, 64'd9), mk(2'd3, 0, 0)};
    send(recs[0]);
    total++;
    if (er !== 1'b1 || rr !== 1'b1 || ov !== 1'b0 || got_d.size() != 0)
      $display("FAIL order_err: err=%0b ready=%0b valid=%0b bytes=%0d, required 1 1 0 0", er, rr, ov, got_d.size());
    else passed++;
    run_recs(0, 1);
  endtask

  task automatic test_overflow();
    rdy_mode = 0;
    sel = 1'b1;
    recs = '{mk(2'd0, 64'd1, 64'd2), mk(2'd0, 64'd3, 64'd4), mk(2'd0, 64'd5, 64'd6), mk(2'd3, 0, 0)};
    run_recs(1, 0);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0;
    do_reset();
    recs = '{mk(2'd0, 64'd123456, 64'd7)};
    send(recs[0]);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    total++;
    if (ov !== 1'b0 || od !== 8'h00 || oa !== 17'd0 || bc !== 18'd0 || dn !== 1'b0 || er !== 1'b0 || rr !== 1'b0)
      $display("FAIL mid_reset: valid=%0b data=%h addr=%0d count=%0d done=%0b err=%0b ready=%0b, required all 0", ov, od, oa, bc, dn, er, rr);
    else passed++;
    @(negedge clk) rst = 1'b0;
    recs = '{mk(2'd0, 64'd1, 64'd1), mk(2'd3, 0, 0)};
    run_recs(0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int n;
      bit sep = 0;
      sel = r >= 6;
      rdy_mode = $urandom_range(0, 1);
      recs.delete();
      n = $urandom_range(2, 7);
      for (int j = 0; j < n; j++) begin
        logic [1:0] t;
        if ($urandom_range(0, 9) < 2) t = 2'($urandom_range(0, 2));
        else if (!sep && j >= n / 2) t = 2'd1;
        else t = sep ? 2'd2 : 2'd0;
        if (t == 2'd1) sep = 1;
        recs.push_back(mk(t, rv(), rv()));
      end
      recs.push_back(mk(2'd3, 0, 0));
      run_recs(1, 0);
    end
    sel = 1'b0;
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_id_extremes();
    test_stall();
    test_order_err();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
